// File: rtl/sum_acc_pkg.sv
// Shared types and constants for the adder-result accumulator.
// Adder results are 5 bits wide: {carry, sum[3:0]}.
package sum_acc_pkg;

    localparam int RES_W = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/sum_acc_sat_add.sv
// Combinational ACC_W-bit adder with a 5-bit addend and carry-out detection.
// Build option: define SATURATE_EN to clamp the result at 2^ACC_W-1 on overflow.
module sum_acc_sat_add
    import sum_acc_pkg::*;
#(
    parameter int ACC_W = 8
) (
    input  logic [ACC_W-1:0] i_acc,
    input  logic [RES_W-1:0] i_addend,
    output logic [ACC_W-1:0] o_result,
    output logic             o_ovf
);

    logic [ACC_W:0] w_sum;

    assign w_sum = {1'b0, i_acc} + {{(ACC_W+1-RES_W){1'b0}}, i_addend};
    assign o_ovf = w_sum[ACC_W];

`ifdef SATURATE_EN
    assign o_result = o_ovf ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
`else
    assign o_result = w_sum[ACC_W-1:0];
`endif

endmodule

// File: rtl/sum_accumulator.sv
// Accumulates NUM_SAMPLES adder results per run behind valid/ready handshakes.
// Build option: SATURATE_EN selects clamping instead of wrapping on overflow.
module sum_accumulator
    import sum_acc_pkg::*;
#(
    parameter int ACC_W       = 8,
    parameter int NUM_SAMPLES = 4,
    parameter int CNT_W       = $clog2(NUM_SAMPLES + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    input  logic [3:0]       in_sum,
    input  logic             in_carry,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic             out_ovf,
    output logic             busy
);

    state_t           r_state;
    state_t           w_state_next;
    logic [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ovf;

    logic             w_accept;
    logic             w_last;
    logic [ACC_W-1:0] w_add_result;
    logic             w_add_ovf;

    sum_acc_sat_add #(
        .ACC_W(ACC_W)
    ) u_add (
        .i_acc    (r_acc),
        .i_addend ({in_carry, in_sum}),
        .o_result (w_add_result),
        .o_ovf    (w_add_ovf)
    );

    assign w_accept = (r_state == ACCUM) && in_valid;
    assign w_last   = w_accept && (r_cnt == CNT_W'(NUM_SAMPLES - 1));

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start)     w_state_next = ACCUM;
            ACCUM:   if (w_last)    w_state_next = DONE;
            DONE:    if (out_ready) w_state_next = IDLE;
            default:                w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Previous run's total stays visible in IDLE until the next start clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if ((r_state == IDLE) && start) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (w_accept) begin
            r_acc <= w_add_result;
            r_cnt <= r_cnt + CNT_W'(1);
            r_ovf <= r_ovf | w_add_ovf;
        end
    end

    assign in_ready  = (r_state == ACCUM);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state != IDLE);
    assign out_acc   = r_acc;
    assign out_ovf   = r_ovf;

endmodule

// File: tb/tb_sum_accumulator.sv
// Self-checking bench: an 8-bit and a 6-bit accumulator share one stimulus stream
// and are compared against an arithmetic model of the run total (honours SATURATE_EN).
module tb_sum_accumulator;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       in_valid;
    logic [3:0] in_sum;
    logic       in_carry;
    logic       out_ready;

    logic       in_ready_a, out_valid_a, out_ovf_a, busy_a;
    logic [7:0] out_acc_a;
    logic       in_ready_b, out_valid_b, out_ovf_b, busy_b;
    logic [5:0] out_acc_b;

    int checks   = 0;
    int failures = 0;
    int total    = 0;

    always #5 clk = ~clk;

    sum_accumulator #(.ACC_W(8), .NUM_SAMPLES(4)) u_dut_a (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_sum(in_sum),
        .in_carry(in_carry), .in_ready(in_ready_a), .out_valid(out_valid_a),
        .out_ready(out_ready), .out_acc(out_acc_a), .out_ovf(out_ovf_a), .busy(busy_a)
    );

    sum_accumulator #(.ACC_W(6), .NUM_SAMPLES(4)) u_dut_b (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_sum(in_sum),
        .in_carry(in_carry), .in_ready(in_ready_b), .out_valid(out_valid_b),
        .out_ready(out_ready), .out_acc(out_acc_b), .out_ovf(out_ovf_b), .busy(busy_b)
    );

    // Reference: the run total is a plain integer sum; overflow means it crossed 2^w.
    function automatic int exp_acc(input int sum, input int w);
        int lim;
        lim = 1 << w;
        if (sum < lim) return sum;
`ifdef SATURATE_EN
        return lim - 1;
`else
        return sum % lim;
`endif
    endfunction

    function automatic logic exp_ovf(input int sum, input int w);
        return sum >= (1 << w);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        total = 0;
    endtask

    // Presents one sample, then drives idle cycles with junk data on the bus.
    task automatic send(input logic c, input logic [3:0] s, input int gap);
        int n;
        n = 0;
        while (!in_ready_a && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (in_ready_a !== 1'b1) begin
            failures++;
            $display("FAIL send_wait in_ready=%b required=1", in_ready_a);
        end
        in_valid = 1'b1;
        in_carry = c;
        in_sum   = s;
        tick();
        in_valid = 1'b0;
        total += int'({c, s});
        for (int g = 0; g < gap; g++) begin
            in_sum   = 4'($urandom);
            in_carry = 1'($urandom);
            tick();
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) tick();
        checks++;
        if ({out_acc_a, out_ovf_a, in_ready_a, out_valid_a, busy_a} !== 12'd0 ||
            {out_acc_b, out_ovf_b, in_ready_b, out_valid_b, busy_b} !== 10'd0) begin
            failures++;
            $display("FAIL reset_state a=%h/%b%b%b%b b=%h/%b%b%b%b required all zero",
                     out_acc_a, out_ovf_a, in_ready_a, out_valid_a, busy_a,
                     out_acc_b, out_ovf_b, in_ready_b, out_valid_b, busy_b);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (in_ready_a !== 1'b0 || busy_a !== 1'b0) begin
            failures++;
            $display("FAIL reset_release in_ready=%b busy=%b required 0/0", in_ready_a, busy_a);
        end
    endtask

    task automatic test_basic();
        do_start();
        send(1'b0, 4'h0, 0);
        send(1'b0, 4'h2, 0);
        send(1'b0, 4'hF, 0);
        send(1'b1, 4'hE, 0);
        checks++;
        if (out_valid_a !== 1'b1 || out_acc_a !== 8'd47 || out_ovf_a !== 1'b0) begin
            failures++;
            $display("FAIL basic_a valid=%b acc=%0d ovf=%b required 1/47/0",
                     out_valid_a, out_acc_a, out_ovf_a);
        end
        checks++;
        if (int'(out_acc_b) !== exp_acc(total, 6) || out_ovf_b !== exp_ovf(total, 6)) begin
            failures++;
            $display("FAIL basic_b acc=%0d ovf=%b required %0d/%b",
                     out_acc_b, out_ovf_b, exp_acc(total, 6), exp_ovf(total, 6));
        end
        handshake();
        checks++;
        if (busy_a !== 1'b0 || out_valid_a !== 1'b0 || out_acc_a !== 8'd47) begin
            failures++;
            $display("FAIL basic_idle busy=%b valid=%b acc=%0d required 0/0/47",
                     busy_a, out_valid_a, out_acc_a);
        end
    endtask

    task automatic test_overflow_back_to_back();
        do_start();
        for (int i = 0; i < 4; i++) send(1'b1, 4'hE, 0);
        checks++;
        if (out_acc_a !== 8'd120 || out_ovf_a !== 1'b0) begin
            failures++;
            $display("FAIL ovf_a acc=%0d ovf=%b required 120/0", out_acc_a, out_ovf_a);
        end
        checks++;
        if (int'(out_acc_b) !== exp_acc(total, 6) || out_ovf_b !== 1'b1) begin
            failures++;
            $display("FAIL ovf_b acc=%0d ovf=%b required %0d/1", out_acc_b, out_ovf_b,
                     exp_acc(total, 6));
        end
        handshake();
        do_start();
        checks++;
        if (out_acc_b !== 6'd0 || out_ovf_b !== 1'b0 || busy_b !== 1'b1) begin
            failures++;
            $display("FAIL b2b_clear acc=%0d ovf=%b busy=%b required 0/0/1",
                     out_acc_b, out_ovf_b, busy_b);
        end
        for (int i = 0; i < 4; i++) send(1'b0, 4'h1, 0);
        checks++;
        if (out_acc_a !== 8'd4 || out_acc_b !== 6'd4 || out_ovf_b !== 1'b0 || out_valid_b !== 1'b1) begin
            failures++;
            $display("FAIL b2b_run acc_a=%0d acc_b=%0d ovf_b=%b valid=%b required 4/4/0/1",
                     out_acc_a, out_acc_b, out_ovf_b, out_valid_b);
        end
        handshake();
    endtask

    task automatic test_backpressure();
        do_start();
        send(1'b0, 4'h0, 3);
        send(1'b0, 4'h2, 3);
        send(1'b0, 4'hF, 3);
        send(1'b1, 4'hE, 0);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (out_valid_a !== 1'b1 || out_acc_a !== 8'd47 || in_ready_a !== 1'b0) begin
                failures++;
                $display("FAIL hold_%0d valid=%b acc=%0d in_ready=%b required 1/47/0",
                         i, out_valid_a, out_acc_a, in_ready_a);
            end
            tick();
        end
        handshake();
        checks++;
        if (busy_a !== 1'b0 || out_valid_a !== 1'b0) begin
            failures++;
            $display("FAIL hold_release busy=%b valid=%b required 0/0", busy_a, out_valid_a);
        end
    endtask

    task automatic test_ignored();
        do_start();
        send(1'b0, 4'h0, 0);
        send(1'b0, 4'h2, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        send(1'b0, 4'hF, 0);
        send(1'b1, 4'hE, 0);
        checks++;
        if (out_valid_a !== 1'b1 || out_acc_a !== 8'd47) begin
            failures++;
            $display("FAIL start_in_accum valid=%b acc=%0d required 1/47", out_valid_a, out_acc_a);
        end
        start     = 1'b1;
        out_ready = 1'b1;
        tick();
        start     = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (busy_a !== 1'b0 || out_acc_a !== 8'd47) begin
            failures++;
            $display("FAIL start_on_handshake busy=%b acc=%0d required 0/47", busy_a, out_acc_a);
        end
        in_valid = 1'b1;
        in_carry = 1'b0;
        in_sum   = 4'hF;
        repeat (3) tick();
        in_valid = 1'b0;
        checks++;
        if (out_acc_a !== 8'd47 || busy_a !== 1'b0 || in_ready_a !== 1'b0) begin
            failures++;
            $display("FAIL valid_in_idle acc=%0d busy=%b in_ready=%b required 47/0/0",
                     out_acc_a, busy_a, in_ready_a);
        end
    endtask

    task automatic test_reset_midrun();
        do_start();
        send(1'b0, 4'hF, 0);
        send(1'b1, 4'hE, 0);
        rst = 1'b1;
        #1;
        checks++;
        if (out_acc_a !== 8'd0 || out_acc_b !== 6'd0 || busy_a !== 1'b0 ||
            in_ready_a !== 1'b0 || out_valid_a !== 1'b0 || out_ovf_b !== 1'b0) begin
            failures++;
            $display("FAIL async_reset acc_a=%0d acc_b=%0d busy=%b in_ready=%b valid=%b required 0/0/0/0/0",
                     out_acc_a, out_acc_b, busy_a, in_ready_a, out_valid_a);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (in_ready_a !== 1'b0 || busy_a !== 1'b0) begin
            failures++;
            $display("FAIL after_reset in_ready=%b busy=%b required 0/0", in_ready_a, busy_a);
        end
        do_start();
        send(1'b0, 4'h0, 0);
        send(1'b0, 4'h2, 0);
        send(1'b0, 4'hF, 0);
        send(1'b1, 4'hE, 0);
        checks++;
        if (out_valid_a !== 1'b1 || out_acc_a !== 8'd47) begin
            failures++;
            $display("FAIL rerun valid=%b acc=%0d required 1/47", out_valid_a, out_acc_a);
        end
        handshake();
    endtask

    task automatic test_random();
        int n;
        for (int r = 0; r < 20; r++) begin
            do_start();
            for (int i = 0; i < 4; i++)
                send(1'($urandom), 4'($urandom), (i == 3) ? 0 : int'($urandom_range(0, 2)));
            checks++;
            if (out_valid_a !== 1'b1 || int'(out_acc_a) !== exp_acc(total, 8) ||
                out_ovf_a !== exp_ovf(total, 8)) begin
                failures++;
                $display("FAIL rand_a run=%0d valid=%b acc=%0d ovf=%b required 1/%0d/%b",
                         r, out_valid_a, out_acc_a, out_ovf_a, exp_acc(total, 8), exp_ovf(total, 8));
            end
            checks++;
            if (out_valid_b !== 1'b1 || int'(out_acc_b) !== exp_acc(total, 6) ||
                out_ovf_b !== exp_ovf(total, 6)) begin
                failures++;
                $display("FAIL rand_b run=%0d valid=%b acc=%0d ovf=%b required 1/%0d/%b",
                         r, out_valid_b, out_acc_b, out_ovf_b, exp_acc(total, 6), exp_ovf(total, 6));
            end
            n = int'($urandom_range(0, 3));
            repeat (n) tick();
            handshake();
            $display("run %0d total=%0d acc_a=%0d acc_b=%0d ovf_b=%b", r, total,
                     out_acc_a, out_acc_b, out_ovf_b);
        end
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        in_valid  = 1'b0;
        in_sum    = 4'h0;
        in_carry  = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_basic();
        test_overflow_back_to_back();
        test_backpressure();
        test_ignored();
        test_reset_midrun();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
